ysyx_24100006_memu: RTL and testbench
=====================================

YSYX_24100006_MEMU -- requirements
Module: ysyx_24100006_memu

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have upstream ports from EXE_MEM: mem_out_valid in 1 upstream valid; mem_out_ready out 1 upstream ready; alu_result in 32 address or ALU value; store_data in 32 rs2 value; Mem_Mask_M in 3 funct3 size/sign; sram_read_write_M in 2 bit0=load, bit1=store; Gpr_Write_M in 1; Gpr_Write_Addr_M in 4; wdata_gpr_M in 32.
REQ-003 SHALL have downstream ports to MEM_WB: mem_in_valid out 1 valid; mem_in_ready in 1 ready; Gpr_Write_W out 1; Gpr_Write_Addr_W out 4; wdata_gpr_W out 32 final writeback value; mem_err out 1 bus error flag.
REQ-004 SHALL have bus ports: req_valid out 1; req_ready in 1; req_we out 1; req_addr out 32; req_wdata out 32; req_wstrb out 4; rsp_valid in 1; rsp_rdata in 32; rsp_err in 1.
REQ-005 SHALL have forwarding ports: mem_is_load out 1 (held op is a load not yet returned); mem_fw_data out 32 (= wdata_gpr_W).

Function
REQ-006 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-007 mem_out_ready SHALL be 1 only in IDLE.
REQ-008 On IDLE with mem_out_valid=1, SHALL capture all upstream fields; sram_read_write_M==00 -> DONE, else -> REQ.
REQ-009 sram_read_write_M==11 SHALL be treated as a store.
REQ-010 Non-memory op: wdata_gpr_W = captured wdata_gpr_M, mem_err=0; latency 1 cycle from accept to mem_in_valid.
REQ-011 In REQ, req_valid=1 with req_addr={addr[31:2],2'b00}, req_we=store; stay until req_ready=1, then -> WAIT. Request fields SHALL be stable while req_valid=1.
REQ-012 Store byte (000): wstrb=0001<<addr[1:0], wdata=byte replicated x4; half (001): wstrb=0011<<{addr[1],1'b0}, wdata=half replicated x2; word (010): wstrb=1111, wdata=store_data. Unlisted encodings SHALL behave as word.
REQ-013 Loads SHALL drive req_wstrb=0000, req_wdata=0.
REQ-014 In WAIT, on rsp_valid=1, SHALL latch result and -> DONE; rsp_valid in IDLE/REQ/DONE SHALL be ignored.
REQ-015 Load data: byte lane = rdata>>(8*addr[1:0]); half lane = rdata>>(16*addr[1]); 000 sign-extend byte, 100 zero-extend byte, 001 sign-extend half, 101 zero-extend half, 010 full word; addr[0] for half and addr[1:0] for word SHALL be ignored (no misalign trap).
REQ-016 Load result SHALL replace wdata_gpr_W; store SHALL pass captured wdata_gpr_M.
REQ-017 mem_err SHALL equal latched rsp_err; on error Gpr_Write_W SHALL be forced 0.
REQ-018 In DONE, mem_in_valid=1 and outputs stable until mem_in_ready=1, then -> IDLE; no new accept in the same cycle (max throughput 1 op per 2 cycles).
REQ-019 mem_is_load SHALL be 1 in REQ/WAIT for loads, else 0.
REQ-020 Gpr_Write_W/Gpr_Write_Addr_W SHALL reflect captured values, except per REQ-017.

Reset
REQ-021 On reset=1 at a clk edge, state SHALL go IDLE regardless of current state, including mid-REQ/WAIT.
REQ-022 After reset: mem_in_valid=0, req_valid=0, req_we=0, req_wstrb=0, mem_err=0, Gpr_Write_W=0, mem_is_load=0, wdata_gpr_W=0, Gpr_Write_Addr_W=0, req_addr=0, req_wdata=0.
REQ-023 A rsp_valid arriving after reset for a pre-reset request SHALL be ignored (state IDLE).

Verification
REQ-024 lb at addr 0x80000003, rdata=0x80FF1234 -> req_addr=0x80000000, wstrb=0000, wdata_gpr_W=0xFFFFFF80; lbu same -> 0x00000080.
REQ-025 sh addr 0x80000002, store_data=0x0000ABCD -> req_we=1, wstrb=1100, wdata=0xABCDABCD, Gpr_Write_W=0.
REQ-026 ALU op (sram_read_write=00, wdata_gpr_M=0x1234) -> mem_in_valid next cycle, wdata_gpr_W=0x1234, no req_valid ever.
REQ-027 req_ready held 0 for 3 cycles, then mem_in_ready held 0 for 2 cycles in DONE -> req fields and outputs stable throughout, mem_out_ready=0 until handoff.
REQ-028 lw with rsp_err=1, Gpr_Write_M=1 -> mem_err=1, Gpr_Write_W=0.
REQ-029 reset asserted in WAIT, rsp_valid arrives the next cycle -> stays IDLE, mem_in_valid=0, mem_out_ready=1.

Source files
------------

// File: rtl/ysyx_24100006_memu.sv
// Memory stage unit: takes one op from EXE_MEM, issues at most one bus
// request, shapes load data / store lanes, and hands the result to MEM_WB.
module ysyx_24100006_memu (
  input  logic        clk,
  input  logic        reset,
  // upstream (EXE_MEM)
  input  logic        mem_out_valid,
  output logic        mem_out_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  Mem_Mask_M,
  input  logic [1:0]  sram_read_write_M,
  input  logic        Gpr_Write_M,
  input  logic [3:0]  Gpr_Write_Addr_M,
  input  logic [31:0] wdata_gpr_M,
  // downstream (MEM_WB)
  output logic        mem_in_valid,
  input  logic        mem_in_ready,
  output logic        Gpr_Write_W,
  output logic [3:0]  Gpr_Write_Addr_W,
  output logic [31:0] wdata_gpr_W,
  output logic        mem_err,
  // data bus
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_err,
  // forwarding
  output logic        mem_is_load,
  output logic [31:0] mem_fw_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  mask_q, mask_d;
  logic        is_load_q, is_load_d;
  logic        gwe_q, gwe_d;
  logic [3:0]  gaddr_q, gaddr_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;

  logic        accept;
  logic        in_store, in_load, in_mem;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [31:0] ld_bsh, ld_hsh, ld_val;

  assign accept   = (state_q == IDLE) && mem_out_valid;
  // bit1 wins over bit0, so 2'b11 is a store
  assign in_store = sram_read_write_M[1];
  assign in_load  = sram_read_write_M[0] & ~sram_read_write_M[1];
  assign in_mem   = |sram_read_write_M;

  // store lane shaping from the incoming op
  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = store_data;
    case (Mem_Mask_M)
      3'b000: begin
        st_strb  = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      3'b001: begin
        st_strb  = 4'b0011 << {alu_result[1], 1'b0};
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // load extraction; misaligned low address bits are simply dropped
  always_comb begin
    ld_bsh = rsp_rdata >> {addr_lo_q, 3'b000};
    ld_hsh = rsp_rdata >> {addr_lo_q[1], 4'b0000};
    case (mask_q)
      3'b000:  ld_val = {{24{ld_bsh[7]}}, ld_bsh[7:0]};
      3'b100:  ld_val = {24'h0, ld_bsh[7:0]};
      3'b001:  ld_val = {{16{ld_hsh[15]}}, ld_hsh[15:0]};
      3'b101:  ld_val = {16'h0, ld_hsh[15:0]};
      default: ld_val = rsp_rdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_out_valid) state_d = in_mem ? REQ : DONE;
      REQ:  if (req_ready)     state_d = WAIT;
      WAIT: if (rsp_valid)     state_d = DONE;
      DONE: if (mem_in_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_out_ready = (state_q == IDLE);
    req_valid     = (state_q == REQ);
    mem_in_valid  = (state_q == DONE);
    mem_is_load   = is_load_q && ((state_q == REQ) || (state_q == WAIT));
  end

  // datapath next values
  always_comb begin
    addr_lo_d   = addr_lo_q;
    mask_d      = mask_q;
    is_load_d   = is_load_q;
    gwe_d       = gwe_q;
    gaddr_d     = gaddr_q;
    result_d    = result_q;
    err_d       = err_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    if (accept) begin
      addr_lo_d   = alu_result[1:0];
      mask_d      = Mem_Mask_M;
      is_load_d   = in_load;
      gwe_d       = Gpr_Write_M;
      gaddr_d     = Gpr_Write_Addr_M;
      result_d    = wdata_gpr_M;
      err_d       = 1'b0;
      req_we_d    = in_store;
      req_addr_d  = in_mem ? {alu_result[31:2], 2'b00} : 32'h0;
      req_wdata_d = in_store ? st_wdata : 32'h0;
      req_wstrb_d = in_store ? st_strb : 4'b0000;
    end else if ((state_q == WAIT) && rsp_valid) begin
      err_d = rsp_err;
      if (is_load_q) result_d = ld_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lo_q   <= 2'b00;
      mask_q      <= 3'b000;
      is_load_q   <= 1'b0;
      gwe_q       <= 1'b0;
      gaddr_q     <= 4'h0;
      result_q    <= 32'h0;
      err_q       <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'b0000;
    end else begin
      addr_lo_q   <= addr_lo_d;
      mask_q      <= mask_d;
      is_load_q   <= is_load_d;
      gwe_q       <= gwe_d;
      gaddr_q     <= gaddr_d;
      result_q    <= result_d;
      err_q       <= err_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
    end
  end

  assign req_we           = req_we_q;
  assign req_addr         = req_addr_q;
  assign req_wdata        = req_wdata_q;
  assign req_wstrb        = req_wstrb_q;
  assign wdata_gpr_W      = result_q;
  assign mem_fw_data      = result_q;
  assign mem_err          = err_q;
  assign Gpr_Write_W      = gwe_q & ~err_q;
  assign Gpr_Write_Addr_W = gaddr_q;

endmodule

// File: tb/tb_ysyx_24100006_memu.sv
// Directed bench for the memory stage: expectations queued at issue, checked
// by a monitor on bus and writeback handshakes.
module tb_ysyx_24100006_memu;

  logic        clk, reset;
  logic        mem_out_valid, mem_out_ready;
  logic [31:0] alu_result, store_data, wdata_gpr_M;
  logic [2:0]  Mem_Mask_M;
  logic [1:0]  sram_read_write_M;
  logic        Gpr_Write_M;
  logic [3:0]  Gpr_Write_Addr_M;
  logic        mem_in_valid, mem_in_ready;
  logic        Gpr_Write_W;
  logic [3:0]  Gpr_Write_Addr_W;
  logic [31:0] wdata_gpr_W;
  logic        mem_err;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_is_load;
  logic [31:0] mem_fw_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic        gwe;
    logic [3:0]  gaddr;
    logic        err;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t mon_b;
  rsp_t mon_r;

  ysyx_24100006_memu dut (
    .clk(clk), .reset(reset),
    .mem_out_valid(mem_out_valid), .mem_out_ready(mem_out_ready),
    .alu_result(alu_result), .store_data(store_data), .Mem_Mask_M(Mem_Mask_M),
    .sram_read_write_M(sram_read_write_M), .Gpr_Write_M(Gpr_Write_M),
    .Gpr_Write_Addr_M(Gpr_Write_Addr_M), .wdata_gpr_M(wdata_gpr_M),
    .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready),
    .Gpr_Write_W(Gpr_Write_W), .Gpr_Write_Addr_W(Gpr_Write_Addr_W),
    .wdata_gpr_W(wdata_gpr_W), .mem_err(mem_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_is_load(mem_is_load), .mem_fw_data(mem_fw_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // monitor: pops expectations on each handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready) begin
        if (bus_q.size() == 0) flag("bus_unexpected");
        else begin
          mon_b = bus_q.pop_front();
          chk("bus_addr",  req_addr,         mon_b.addr);
          chk("bus_we",    {31'h0, req_we},  {31'h0, mon_b.we});
          chk("bus_wstrb", {28'h0, req_wstrb}, {28'h0, mon_b.strb});
          chk("bus_wdata", req_wdata,        mon_b.wdata);
        end
      end else if (req_valid && bus_q.size() == 0) begin
        flag("req_valid_spurious");
      end
      if (mem_in_valid && mem_in_ready) begin
        if (rsp_q.size() == 0) flag("wb_unexpected");
        else begin
          mon_r = rsp_q.pop_front();
          chk("wb_wdata", wdata_gpr_W,             mon_r.wdata);
          chk("wb_gwe",   {31'h0, Gpr_Write_W},    {31'h0, mon_r.gwe});
          chk("wb_gaddr", {28'h0, Gpr_Write_Addr_W}, {28'h0, mon_r.gaddr});
          chk("wb_err",   {31'h0, mem_err},        {31'h0, mon_r.err});
          chk("wb_fw",    mem_fw_data,             mon_r.wdata);
        end
      end
    end
  end

  task automatic do_op(
    input logic [1:0] rw, input logic [2:0] mask, input logic [31:0] addr,
    input logic [31:0] sdata, input logic [31:0] wdm, input logic gwe,
    input logic [3:0] gaddr, input logic [31:0] rdata, input logic err,
    input int rdy_dly, input int rsp_dly, input int stall,
    input logic [31:0] e_wdata, input logic e_gwe, input logic e_err,
    input logic [31:0] e_baddr, input logic [3:0] e_strb, input logic [31:0] e_bwdata);
    int n;
    if (rw != 2'b00) bus_q.push_back(bus_t'{e_baddr, rw[1], e_strb, e_bwdata});
    rsp_q.push_back(rsp_t'{e_wdata, e_gwe, gaddr, e_err});
    @(posedge clk); #1;
    sram_read_write_M = rw; Mem_Mask_M = mask; alu_result = addr;
    store_data = sdata; wdata_gpr_M = wdm; Gpr_Write_M = gwe;
    Gpr_Write_Addr_M = gaddr; mem_out_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mem_out_ready && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) flag("accept_timeout");
    @(posedge clk); #1;
    mem_out_valid = 1'b0;
    if (rw != 2'b00) begin
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk);
        chk("req_valid_hold", {31'h0, req_valid}, 32'h1);
        chk("req_addr_hold",  req_addr, e_baddr);
        chk("req_wstrb_hold", {28'h0, req_wstrb}, {28'h0, e_strb});
        chk("req_wdata_hold", req_wdata, e_bwdata);
        chk("out_ready_req",  {31'h0, mem_out_ready}, 32'h0);
        @(posedge clk); #1;
      end
      req_ready = 1'b1;
      @(negedge clk);
      chk("is_load_req", {31'h0, mem_is_load}, {31'h0, (rw == 2'b01)});
      @(posedge clk); #1;
      req_ready = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
        @(negedge clk);
        chk("wait_no_valid", {31'h0, mem_in_valid}, 32'h0);
        chk("is_load_wait",  {31'h0, mem_is_load}, {31'h0, (rw == 2'b01)});
        @(posedge clk); #1;
      end
      rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
      @(posedge clk); #1;
      rsp_valid = 1'b0; rsp_rdata = 32'h0; rsp_err = 1'b0;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("done_valid",    {31'h0, mem_in_valid}, 32'h1);
      chk("done_wdata",    wdata_gpr_W, e_wdata);
      chk("done_gwe",      {31'h0, Gpr_Write_W}, {31'h0, e_gwe});
      chk("done_err",      {31'h0, mem_err}, {31'h0, e_err});
      chk("done_out_rdy",  {31'h0, mem_out_ready}, 32'h0);
      chk("done_is_load",  {31'h0, mem_is_load}, 32'h0);
      @(posedge clk); #1;
    end
    mem_in_ready = 1'b1;
    @(posedge clk); #1;
    mem_in_ready = 1'b0;
    @(negedge clk);
    chk("back_idle_rdy",   {31'h0, mem_out_ready}, 32'h1);
    chk("back_idle_valid", {31'h0, mem_in_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_out_valid = 1'b0; alu_result = 32'h0; store_data = 32'h0;
    Mem_Mask_M = 3'b000; sram_read_write_M = 2'b00; Gpr_Write_M = 1'b0;
    Gpr_Write_Addr_M = 4'h0; wdata_gpr_M = 32'h0; mem_in_ready = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0; rsp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_valid",  {31'h0, mem_in_valid}, 32'h0);
    chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
    chk("rst_req_we",    {31'h0, req_we}, 32'h0);
    chk("rst_wstrb",     {28'h0, req_wstrb}, 32'h0);
    chk("rst_err",       {31'h0, mem_err}, 32'h0);
    chk("rst_gwe",       {31'h0, Gpr_Write_W}, 32'h0);
    chk("rst_is_load",   {31'h0, mem_is_load}, 32'h0);
    chk("rst_wdata",     wdata_gpr_W, 32'h0);
    chk("rst_gaddr",     {28'h0, Gpr_Write_Addr_W}, 32'h0);
    chk("rst_req_addr",  req_addr, 32'h0);
    chk("rst_req_wdata", req_wdata, 32'h0);
    chk("rst_out_ready", {31'h0, mem_out_ready}, 32'h1);

    // rw   mask    addr          sdata         wdm          gwe gaddr rdata        err rdy rsp stall e_wdata      e_gwe e_err e_baddr       strb     bwdata
    do_op(2'b01, 3'b000, 32'h80000003, 32'h0,        32'h0,       1, 4'd5, 32'h80FF1234, 0, 0, 0, 1, 32'hFFFFFF80, 1, 0, 32'h80000000, 4'b0000, 32'h0);
    do_op(2'b01, 3'b100, 32'h80000003, 32'h0,        32'h0,       1, 4'd5, 32'h80FF1234, 0, 1, 1, 0, 32'h00000080, 1, 0, 32'h80000000, 4'b0000, 32'h0);
    do_op(2'b01, 3'b001, 32'h80000002, 32'h0,        32'h0,       1, 4'd6, 32'h80FF1234, 0, 0, 2, 0, 32'hFFFF80FF, 1, 0, 32'h80000000, 4'b0000, 32'h0);
    do_op(2'b01, 3'b101, 32'h80000002, 32'h0,        32'h0,       1, 4'd6, 32'h80FF1234, 0, 0, 0, 0, 32'h000080FF, 1, 0, 32'h80000000, 4'b0000, 32'h0);
    do_op(2'b01, 3'b001, 32'h80000001, 32'h0,        32'h0,       1, 4'd2, 32'h80FF1234, 0, 0, 0, 0, 32'h00001234, 1, 0, 32'h80000000, 4'b0000, 32'h0);
    do_op(2'b01, 3'b010, 32'h80000007, 32'h0,        32'h0,       1, 4'd9, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0, 32'h80000004, 4'b0000, 32'h0);
    do_op(2'b10, 3'b000, 32'h80000001, 32'h000000A5, 32'h11,      0, 4'd1, 32'h0,        0, 0, 0, 0, 32'h00000011, 0, 0, 32'h80000000, 4'b0010, 32'hA5A5A5A5);
    do_op(2'b10, 3'b001, 32'h80000002, 32'h0000ABCD, 32'h55,      0, 4'd0, 32'h0,        0, 0, 0, 1, 32'h00000055, 0, 0, 32'h80000000, 4'b1100, 32'hABCDABCD);
    do_op(2'b10, 3'b010, 32'h8000000C, 32'h12345678, 32'h0,       0, 4'd0, 32'h0,        0, 0, 0, 0, 32'h00000000, 0, 0, 32'h8000000C, 4'b1111, 32'h12345678);
    do_op(2'b10, 3'b011, 32'h80000011, 32'hCAFEBABE, 32'h0,       0, 4'd0, 32'h0,        0, 0, 0, 0, 32'h00000000, 0, 0, 32'h80000010, 4'b1111, 32'hCAFEBABE);
    do_op(2'b11, 3'b000, 32'h80000000, 32'h0000127F, 32'h0,       0, 4'd0, 32'h0,        0, 0, 0, 0, 32'h00000000, 0, 0, 32'h80000000, 4'b0001, 32'h7F7F7F7F);
    do_op(2'b00, 3'b010, 32'h00001234, 32'h0,        32'h1234,    1, 4'd3, 32'h0,        0, 0, 0, 1, 32'h00001234, 1, 0, 32'h0,        4'b0000, 32'h0);
    do_op(2'b01, 3'b010, 32'h80000020, 32'h0,        32'h0,       1, 4'd7, 32'hCAFEF00D, 1, 0, 0, 1, 32'hCAFEF00D, 0, 1, 32'h80000020, 4'b0000, 32'h0);
    do_op(2'b01, 3'b010, 32'h80000040, 32'h0,        32'h0,       1, 4'd8, 32'h0BADF00D, 0, 3, 1, 2, 32'h0BADF00D, 1, 0, 32'h80000040, 4'b0000, 32'h0);

    // a stray response while idle must not produce a writeback
    @(posedge clk); #1;
    rsp_valid = 1'b1; rsp_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("idle_rsp_ignored", {31'h0, mem_in_valid}, 32'h0);
    chk("idle_rsp_ready",   {31'h0, mem_out_ready}, 32'h1);

    // reset while waiting for a load response; late response is dropped
    bus_q.push_back(bus_t'{32'h80000100, 1'b0, 4'b0000, 32'h0});
    @(posedge clk); #1;
    sram_read_write_M = 2'b01; Mem_Mask_M = 3'b010; alu_result = 32'h80000100;
    Gpr_Write_M = 1'b1; Gpr_Write_Addr_M = 4'd4; mem_out_valid = 1'b1;
    @(posedge clk); #1;
    mem_out_valid = 1'b0; req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    chk("wait_is_load", {31'h0, mem_is_load}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("rstw_in_valid",  {31'h0, mem_in_valid}, 32'h0);
    chk("rstw_out_ready", {31'h0, mem_out_ready}, 32'h1);
    chk("rstw_wdata",     wdata_gpr_W, 32'h0);
    chk("rstw_is_load",   {31'h0, mem_is_load}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rstw_still_idle", {31'h0, mem_in_valid}, 32'h0);

    chk("bus_q_drained", bus_q.size(), 32'h0);
    chk("rsp_q_drained", rsp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
